// File: rtl/decode_imm_queue.sv
// Fetch-to-decode instruction queue. Each entry is classified at enqueue into
// the immediate-type code used by the sign-extender, plus an illegal-opcode flag.
module decode_imm_queue #(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic [31:0]              i_instr,
    input  logic [PC_W-1:0]          i_pc,
    input  logic                     i_flush,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [31:0]              o_instr,
    output logic [PC_W-1:0]          o_pc,
    output logic [2:0]               o_imm_type,
    output logic                     o_illegal,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    localparam logic [2:0] TYPE_RT   = 3'd0;
    localparam logic [2:0] TYPE_IT   = 3'd1;
    localparam logic [2:0] TYPE_ST   = 3'd2;
    localparam logic [2:0] TYPE_BT   = 3'd3;
    localparam logic [2:0] TYPE_JT   = 3'd4;
    localparam logic [2:0] TYPE_UT   = 3'd5;
    localparam logic [2:0] TYPE_NONE = 3'd7;

    // Returns {illegal, type}; unknown opcodes (including compressed forms) are illegal.
    function automatic logic [3:0] classify(input logic [6:0] opc);
        logic [3:0] res;
        case (opc)
            7'b0110011: res = {1'b0, TYPE_RT};
            7'b0010011,
            7'b0000011,
            7'b1100111,
            7'b1110011: res = {1'b0, TYPE_IT};
            7'b0100011: res = {1'b0, TYPE_ST};
            7'b1100011: res = {1'b0, TYPE_BT};
            7'b1101111: res = {1'b0, TYPE_JT};
            7'b0110111,
            7'b0010111: res = {1'b0, TYPE_UT};
            default:    res = {1'b1, TYPE_NONE};
        endcase
        return res;
    endfunction

    logic [31:0]     instr_mem_r   [DEPTH];
    logic [PC_W-1:0] pc_mem_r      [DEPTH];
    logic [2:0]      type_mem_r    [DEPTH];
    logic            illegal_mem_r [DEPTH];

    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;

    logic       enq_s;
    logic       deq_s;
    logic [3:0] class_s;

    assign o_ready = (count_r != FULL_CNT);
    assign o_valid = (count_r != {CW{1'b0}});
    assign o_count = count_r;
    assign enq_s   = i_valid && o_ready && !i_flush;
    assign deq_s   = o_valid && i_ready && !i_flush;
    assign class_s = classify(i_instr[6:0]);

    // Entry storage; contents are deliberately not reset or flushed.
    always_ff @(posedge i_clk) begin
        if (enq_s) begin
            instr_mem_r[wr_ptr_r]   <= i_instr;
            pc_mem_r[wr_ptr_r]      <= i_pc;
            type_mem_r[wr_ptr_r]    <= class_s[2:0];
            illegal_mem_r[wr_ptr_r] <= class_s[3];
        end
    end

    // Pointer and occupancy bookkeeping; flush wins over any transfer.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else if (i_flush) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (enq_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (deq_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({enq_s, deq_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Head presentation, forced to neutral values when the queue is empty.
    always_comb begin
        o_instr    = 32'd0;
        o_pc       = {PC_W{1'b0}};
        o_imm_type = TYPE_NONE;
        o_illegal  = 1'b0;
        if (o_valid) begin
            o_instr    = instr_mem_r[rd_ptr_r];
            o_pc       = pc_mem_r[rd_ptr_r];
            o_imm_type = type_mem_r[rd_ptr_r];
            o_illegal  = illegal_mem_r[rd_ptr_r];
        end else begin
            o_instr    = 32'd0;
            o_pc       = {PC_W{1'b0}};
            o_imm_type = TYPE_NONE;
            o_illegal  = 1'b0;
        end
    end

endmodule
